apb_requester: RTL and testbench



---
 rtl/apb_requester_if.sv | 28 ++
 rtl/apb_requester.sv | 199 +++++++++++++++++++
 tb/tb_apb_requester.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// APB5 requester/completer bus bundle; the requester drives the address/control/write-data half.
// Purely combinational wiring, no storage of its own.
// Flow control is PREADY from the completer; the requester holds its outputs while PREADY is low.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// APB5 requester: single-beat cmd valid/ready -> SETUP/ACCESS transfer -> rsp valid/ready (watchdog via APB_REQ_TIMEOUT_EN).
// Latency: accept to rsp_valid = 2 + wait states; at least 4 cycles per transfer with rsp_ready held high.
// Backpressure: cmd_ready only in IDLE; rsp_valid without rsp_ready stalls with the payload frozen.
module apb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    apb_requester_if.master         apb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_requester: DATA_WIDTH must be 8, 16 or 32");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32) begin : g_bad_addr_width
        $error("apb_requester: ADDR_WIDTH must be 1..32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [2:0]            pprot_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;

    logic cmd_fire;
    logic xfer_done;
    logic abort;

    assign cmd_fire  = cmd_valid & cmd_ready;
    // PSLVERR/PRDATA are only meaningful on a psel & penable & pready cycle.
    assign xfer_done = (state == ACCESS) & psel_q & penable_q & apb.pready;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !apb.pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Abort on the cycle whose low PREADY would bring the count to TIMEOUT_CYCLES.
    assign abort = (state == ACCESS) && !apb.pready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_timeout <= 1'b0;
        end else if (xfer_done) begin
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_fire)            state_nxt = SETUP;
            SETUP:                            state_nxt = ACCESS;
            ACCESS:  if (xfer_done || abort)  state_nxt = RESP;
            RESP:    if (rsp_ready)           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered so that every output reads 0 while in reset.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            paddr_q   <= '0;
            pprot_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= cmd_addr;
                        pprot_q   <= cmd_prot;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        pstrb_q   <= cmd_write ? cmd_strb  : '0;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // pwrite/pprot deliberately keep their last value between transfers.
                    if (xfer_done || abort) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (xfer_done) begin
            rsp_rdata <= pwrite_q ? '0 : apb.prdata;
            rsp_err   <= apb.pslverr;
        end else if (abort) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pprot   = pprot_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;

    a_penable_needs_psel: assert property (@(posedge pclk) disable iff (!preset_n)
        penable_q |-> psel_q);

    a_cmd_rsp_exclusive: assert property (@(posedge pclk) disable iff (!preset_n)
        !(cmd_ready && rsp_valid));

    a_access_stable: assert property (@(posedge pclk) disable iff (!preset_n)
        (state == ACCESS && !apb.pready && !abort) |=>
            $stable({paddr_q, pprot_q, psel_q, penable_q, pwrite_q, pwdata_q, pstrb_q}));

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester with a transaction-level timeline model and literal spot checks.
module tb_apb_requester;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .apb(apb)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus for the next command's completer behaviour.
    int            next_waits = 0;
    bit            next_err   = 1'b0;
    logic [DW-1:0] next_rdata = '0;

    // Model: a transfer accepted at edge N is described by j = edges since N.
    bit            busy = 1'b0;
    int            j = 0;
    bit            exp_cmd_ready = 1'b0;
    logic          exp_pwrite = 1'b0;
    logic [2:0]    exp_pprot = '0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [SW-1:0] m_strb = '0;
    logic [DW-1:0] m_rdata = '0;
    int            m_waits = 0;
    int            m_weff = 0;
    bit            m_perr = 1'b0;
    bit            m_err = 1'b0;
    bit            m_to = 1'b0;
    int            acc_count = 0;

    initial forever begin
        @(posedge pclk or negedge preset_n);
        if (!preset_n) begin
            busy = 1'b0; j = 0; exp_cmd_ready = 1'b0; exp_pwrite = 1'b0; exp_pprot = '0;
        end else if (!busy) begin
            if (exp_cmd_ready && cmd_valid) begin
                busy = 1'b1; j = 0;
                m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
                m_strb = cmd_strb; m_waits = next_waits; m_perr = next_err; m_rdata = next_rdata;
`ifdef APB_REQ_TIMEOUT_EN
                m_to = (next_waits >= TO);
`else
                m_to = 1'b0;
`endif
                m_weff = m_to ? TO - 1 : next_waits;
                m_err  = m_to ? 1'b1 : next_err;
                exp_pwrite = cmd_write; exp_pprot = cmd_prot;
                exp_cmd_ready = 1'b0;
                acc_count++;
            end else begin
                exp_cmd_ready = 1'b1;
            end
        end else if (j >= m_weff + 2 && rsp_ready) begin
            busy = 1'b0; exp_cmd_ready = 1'b1;
        end else begin
            j++;
        end
    end

    // Completer: ready after m_waits low ACCESS samples; junk on every non-completing cycle.
    int acc_cnt = 0;
    initial begin
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (apb.psel && apb.penable) begin
                if (acc_cnt == m_waits) begin
                    apb.pready = 1'b1; apb.prdata = m_rdata; apb.pslverr = m_perr;
                end else begin
                    apb.pready = 1'b0; apb.prdata = $urandom; apb.pslverr = 1'($urandom % 2);
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                apb.pready = 1'($urandom % 2); apb.prdata = $urandom; apb.pslverr = 1'($urandom % 2);
            end
        end
    end

    // Compare process: every output against the model on every cycle.
    initial forever begin
        bit ps, pe, rv;
        @(negedge pclk);
        ps = busy && (j <= m_weff + 1);
        pe = busy && (j >= 1) && (j <= m_weff + 1);
        rv = busy && (j >= m_weff + 2);
        chk("cmd_ready", cmd_ready, exp_cmd_ready);
        chk("psel", apb.psel, ps);
        chk("penable", apb.penable, pe);
        chk("paddr", apb.paddr, ps ? m_addr : '0);
        chk("pwdata", apb.pwdata, (ps && m_write) ? m_wdata : '0);
        chk("pstrb", apb.pstrb, (ps && m_write) ? m_strb : '0);
        chk("pwrite", apb.pwrite, exp_pwrite);
        chk("pprot", apb.pprot, exp_pprot);
        chk("rsp_valid", rsp_valid, rv);
        if (rv) begin
            chk("rsp_rdata", rsp_rdata, (m_write || m_to) ? '0 : m_rdata);
            chk("rsp_err", rsp_err, m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
    end

    // Measurements for the literal expectations.
    int cyc = 0;
    int acc_cyc = 0, rv_cyc = -1, ps_cnt = 0, pe_cnt = 0;
    logic [DW-1:0] cap_rdata = '0;
    logic cap_err = 1'b0, cap_to = 1'b0;

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    initial forever begin
        @(negedge pclk);
        if (cmd_valid && cmd_ready) begin
            acc_cyc = cyc; rv_cyc = -1; ps_cnt = 0; pe_cnt = 0;
        end
        if (apb.psel) ps_cnt++;
        if (apb.penable) pe_cnt++;
        if (rsp_valid && rv_cyc < 0) begin
            rv_cyc = cyc; cap_rdata = rsp_rdata; cap_err = rsp_err; cap_to = rsp_timeout;
        end
    end

    int rsp_mode = 0;   // 0: always ready, 1: random, 2: held low
    initial forever begin
        @(posedge pclk);
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom % 2);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                        input bit err, input logic [DW-1:0] rd);
        int start;
        int n;
        next_waits = waits; next_err = err; next_rdata = rd;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        cmd_valid = 1'b1;
        start = acc_count;
        n = 0;
        while (acc_count == start && n < 200) begin
            @(posedge pclk); #1; n++;
        end
        if (acc_count == start) chk("accept_bound", 1'b0, 1'b1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge pclk); #1; n++;
        end
        if (busy) chk("idle_bound", 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rise_cyc;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_psel", apb.psel, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        preset_n = 1'b1;
        @(posedge pclk); #1;
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write.
        rsp_mode = 0;
        xfer(1'b1, 32'h84, 32'h1234_5678, 4'hF, 3'b010, 0, 1'b0, 32'h0);
        wait_idle();
        chk("wr_latency", 32'(rv_cyc - acc_cyc), 32'd3);
        chk("wr_psel_cycles", 32'(ps_cnt), 32'd2);
        chk("wr_penable_cycles", 32'(pe_cnt), 32'd1);
        chk("wr_err", cap_err, 1'b0);

        // Read with three wait states.
        xfer(1'b0, 32'h84, 32'hFFFF_FFFF, 4'hF, 3'b000, 3, 1'b0, 32'h1234_5678);
        wait_idle();
        chk("rd_latency", 32'(rv_cyc - acc_cyc), 32'd6);
        chk("rd_rdata", cap_rdata, 32'h1234_5678);
        chk("rd_psel_cycles", 32'(ps_cnt), 32'd5);

        // Slave error on a write.
        xfer(1'b1, 32'hFFC, 32'hA5A5_A5A5, 4'h3, 3'b001, 0, 1'b1, 32'h0);
        wait_idle();
        chk("slverr_err", cap_err, 1'b1);
        chk("slverr_timeout", cap_to, 1'b0);

        // Response held off while a second command waits.
        rsp_mode = 2;
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b100, 0, 1'b0, 32'hCAFE_F00D);
        repeat (3) begin @(posedge pclk); #1; end
        rise_cyc = 0;
        fork
            xfer(1'b1, 32'h44, 32'h0BAD_BEEF, 4'hC, 3'b011, 1, 1'b0, 32'h0);
            begin
                repeat (10) begin
                    @(posedge pclk); #1;
                    chk("hold_cmd_ready", cmd_ready, 1'b0);
                    chk("hold_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
                end
                rsp_mode = 0; rsp_ready = 1'b1; rise_cyc = cyc;
            end
        join
        chk("hold_accept_cycle", 32'(acc_cyc - rise_cyc), 32'd1);
        wait_idle();

`ifdef APB_REQ_TIMEOUT_EN
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h7777_7777);
        wait_idle();
        chk("to_latency", 32'(rv_cyc - acc_cyc), 32'(TO + 2));
        chk("to_err", cap_err, 1'b1);
        chk("to_flag", cap_to, 1'b1);
        chk("to_rdata", cap_rdata, 32'h0);
        xfer(1'b1, 32'h104, 32'h5555_AAAA, 4'hF, 3'b000, 1, 1'b0, 32'h0);
        wait_idle();
        chk("after_to_err", cap_err, 1'b0);
        chk("after_to_flag", cap_to, 1'b0);
`endif

        // Randomized traffic with random response backpressure.
        rsp_mode = 1;
        for (int k = 0; k < 150; k++) begin
            xfer(1'($urandom % 2), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 ($urandom % 8 == 0) ? 14 + int'($urandom % 6) : int'($urandom % 5),
                 1'($urandom % 4 == 0), $urandom);
            repeat ($urandom % 3) begin @(posedge pclk); #1; end
        end
        rsp_mode = 0;
        wait_idle();

        // Asynchronous reset in the middle of a waited ACCESS.
        xfer(1'b0, 32'h200, 32'h0, 4'h0, 3'b000, 10, 1'b0, 32'h1111_2222);
        repeat (4) @(posedge pclk);
        #3 preset_n = 1'b0;
        #1;
        chk("arst_psel", apb.psel, 1'b0);
        chk("arst_penable", apb.penable, 1'b0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b1;
        repeat (2) begin @(posedge pclk); #1; end
        chk("arst_cmd_ready", cmd_ready, 1'b1);
        repeat (12) begin
            @(posedge pclk); #1;
            chk("arst_no_stale_rsp", rsp_valid, 1'b0);
        end

        rsp_mode = 1;
        for (int k = 0; k < 20; k++) begin
            xfer(1'($urandom % 2), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom % 4), 1'($urandom % 3 == 0), $urandom);
        end
        rsp_mode = 0;
        wait_idle();
        repeat (3) @(posedge pclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
